// File: rtl/asrm_ram_responder_pkg.sv
// Shared definitions for the asrm bus responder: FSM encodings, wait-state
// counter width and the value returned on an address miss.
package asrm_ram_responder_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_WAIT = 2'd1,
    BUS_EXEC = 2'd2,
    BUS_DONE = 2'd3
  } bus_state_e;

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned MISS_RDATA = 0;

endpackage

// File: rtl/asrm_ram_array.sv
// Synchronous single-port word RAM with a registered read; contents are
// never cleared, so it carries no reset.
module asrm_ram_array #(
  parameter int unsigned wordsize   = 16,
  parameter int unsigned depth_log2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [depth_log2-1:0] addr,
  input  logic [wordsize-1:0]   wdata,
  output logic [wordsize-1:0]   rdata
);

  logic [wordsize-1:0] mem [0:(1 << depth_log2)-1];
  logic [wordsize-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/asrm_ram_responder.sv
// Bus target for the asrm CPU: address decode, wait-state sequencing and a
// ready flag in front of a single-port word RAM.
module asrm_ram_responder
  import asrm_ram_responder_pkg::*;
#(
  parameter int unsigned wordsize    = 16,
  parameter int unsigned depth_log2  = 8,
  parameter int unsigned base_addr   = 0,
  parameter int unsigned wait_states = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] wdata,
  input  logic                write_en,
  output logic [wordsize-1:0] rdata,
  output logic                ready,
  output logic                hit
);

  localparam logic [wordsize-1:0] BASE      = wordsize'(base_addr);
  localparam logic [CNT_W-1:0]    WAIT_LOAD = CNT_W'(wait_states);

  // The window ends at the top of the address space if base + depth wraps.
  function automatic logic in_window(input logic [wordsize-1:0] a);
    logic [wordsize-1:0] off;
    off = a - BASE;
    return (a >= BASE) && ((off >> depth_log2) == '0);
  endfunction

  bus_state_e            state_q, state_d;
  logic [wordsize-1:0]   addr_q, addr_d;
  logic [wordsize-1:0]   wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  hit_q, hit_d;
  logic [wordsize-1:0]   rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic [CNT_W-1:0]      counter_q, counter_d;
  logic                  first_q, first_d;

  logic                  capture;
  logic                  start;
  logic                  changed;
  logic                  mem_we;
  logic                  mem_wr_en;
  logic [depth_log2-1:0] mem_idx;
  logic [wordsize-1:0]   mem_rdata;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    hit_d     = hit_q;
    rdata_d   = rdata_q;
    ready_d   = ready_q;
    counter_d = counter_q;
    first_d   = first_q;
    capture   = 1'b0;
    mem_we    = 1'b0;

    changed = (addr != addr_q) || (write_en != we_q) || (wdata != wdata_q);
    start   = first_q || (addr != addr_q) ||
              (write_en && (!we_q || (wdata != wdata_q)));

    case (state_q)
      BUS_IDLE, BUS_DONE: begin
        capture = start;
      end
      BUS_WAIT: begin
        if (changed) begin
          capture = 1'b1;
        end else begin
          counter_d = counter_q - CNT_W'(1);
          if (counter_q <= CNT_W'(1)) begin
            state_d = BUS_EXEC;
          end
        end
      end
      BUS_EXEC: begin
        mem_we = we_q && hit_q;
        if (!hit_q) begin
          rdata_d = wordsize'(MISS_RDATA);
        end else if (we_q) begin
          rdata_d = wdata_q;
        end else begin
          rdata_d = mem_rdata;
        end
        ready_d = 1'b1;
        state_d = BUS_DONE;
      end
      default: begin
        state_d = BUS_IDLE;
      end
    endcase

    if (capture) begin
      addr_d    = addr;
      wdata_d   = wdata;
      we_d      = write_en;
      hit_d     = in_window(addr);
      ready_d   = 1'b0;
      counter_d = WAIT_LOAD;
      first_d   = 1'b0;
      state_d   = (WAIT_LOAD != '0) ? BUS_WAIT : BUS_EXEC;
    end

    // Read address follows the next captured address so the registered
    // RAM output is already valid during the EXEC cycle.
    mem_idx = depth_log2'(addr_d - BASE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= BUS_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      hit_q     <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      counter_q <= '0;
      first_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      hit_q     <= hit_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      counter_q <= counter_d;
      first_q   <= first_d;
    end
  end

  // A reset landing on the EXEC edge must not commit the pending write.
  assign mem_wr_en = mem_we && reset;

  asrm_ram_array #(
    .wordsize  (wordsize),
    .depth_log2(depth_log2)
  ) u_ram (
    .clk  (clk),
    .we   (mem_wr_en),
    .addr (mem_idx),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign hit   = hit_q;

endmodule

// File: tb/tb_asrm_ram_responder.sv
// Self-checking bench: four responder configurations share one bus, checked by
// a directed vector table, hand sequences and a latency/memory reference model.
module tb_asrm_ram_responder;

  localparam int N_INST = 4;

  int ws_cfg   [N_INST] = '{1, 3, 0, 2};
  int base_cfg [N_INST] = '{0, 0, 32'h0100, 32'hFFF8};
  int dl2_cfg  [N_INST] = '{8, 8, 4, 4};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        write_en = 1'b0;

  logic [15:0] rdata_w [N_INST];
  logic        ready_w [N_INST];
  logic        hit_w   [N_INST];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  asrm_ram_responder #(.wordsize(16), .depth_log2(8), .base_addr(0), .wait_states(1)) dut_a (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .write_en(write_en),
    .rdata(rdata_w[0]), .ready(ready_w[0]), .hit(hit_w[0]));
  asrm_ram_responder #(.wordsize(16), .depth_log2(8), .base_addr(0), .wait_states(3)) dut_b (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .write_en(write_en),
    .rdata(rdata_w[1]), .ready(ready_w[1]), .hit(hit_w[1]));
  asrm_ram_responder #(.wordsize(16), .depth_log2(4), .base_addr(32'h0100), .wait_states(0)) dut_c (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .write_en(write_en),
    .rdata(rdata_w[2]), .ready(ready_w[2]), .hit(hit_w[2]));
  asrm_ram_responder #(.wordsize(16), .depth_log2(4), .base_addr(32'hFFF8), .wait_states(2)) dut_d (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .write_en(write_en),
    .rdata(rdata_w[3]), .ready(ready_w[3]), .hit(hit_w[3]));

  task automatic applyStimulus(input logic r, input logic [15:0] a, input logic [15:0] d,
                               input logic we);
    reset    = r;
    addr     = a;
    wdata    = d;
    write_en = we;
  endtask

  task automatic checkOutput(input string name, input int inst, input logic [15:0] got,
                             input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s inst=%0d got=%h expected=%h at %0t", name, inst, got, exp, $time);
    end
  endtask

  task automatic holdEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a request is a countdown of ws+1 edges to its response;
  // only edges before the final one may be restarted by changed inputs.
  int          remain_m [N_INST];
  bit          first_m  [N_INST];
  logic [15:0] c_addr   [N_INST];
  logic [15:0] c_wdata  [N_INST];
  bit          c_we     [N_INST];
  bit          e_ready  [N_INST];
  bit          e_hit    [N_INST];
  logic [15:0] e_rdata  [N_INST];
  bit          rd_known [N_INST];
  logic [15:0] model_mem [int];

  function automatic bit in_range(input int i, input logic [15:0] a);
    int av;
    int top;
    av  = {16'h0, a};
    top = base_cfg[i] + (1 << dl2_cfg[i]);
    if (top > 65536) top = 65536;
    return (av >= base_cfg[i]) && (av < top);
  endfunction

  task automatic modelCapture(input int i);
    c_addr[i]   = addr;
    c_wdata[i]  = wdata;
    c_we[i]     = write_en;
    first_m[i]  = 1'b0;
    e_ready[i]  = 1'b0;
    e_hit[i]    = in_range(i, addr);
    remain_m[i] = ws_cfg[i] + 1;
  endtask

  task automatic modelCommit(input int i);
    int key;
    key = i * 65536 + ({16'h0, c_addr[i]} - base_cfg[i]);
    if (!e_hit[i]) begin
      e_rdata[i]  = 16'h0;
      rd_known[i] = 1'b1;
    end else if (c_we[i]) begin
      model_mem[key] = c_wdata[i];
      e_rdata[i]     = c_wdata[i];
      rd_known[i]    = 1'b1;
    end else if (model_mem.exists(key)) begin
      e_rdata[i]  = model_mem[key];
      rd_known[i] = 1'b1;
    end else begin
      rd_known[i] = 1'b0;
    end
    e_ready[i] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N_INST; i++) begin
      remain_m[i] = 0;  first_m[i] = 1'b1;  c_addr[i] = '0;  c_wdata[i] = '0;
      c_we[i] = 1'b0;   e_ready[i] = 1'b0;  e_hit[i] = 1'b0; e_rdata[i] = '0;
      rd_known[i] = 1'b1;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N_INST; i++) begin
      if (!reset) begin
        first_m[i] = 1'b1;  remain_m[i] = 0;  e_ready[i] = 1'b0;
        e_hit[i] = 1'b0;    e_rdata[i] = '0;  rd_known[i] = 1'b1;
      end else if (remain_m[i] > 1 &&
                   (addr != c_addr[i] || write_en != c_we[i] || wdata != c_wdata[i])) begin
        modelCapture(i);
      end else if (remain_m[i] > 0) begin
        remain_m[i]--;
        if (remain_m[i] == 0) modelCommit(i);
      end else if (first_m[i] || addr != c_addr[i] ||
                   (write_en && (!c_we[i] || wdata != c_wdata[i]))) begin
        modelCapture(i);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N_INST; i++) begin
      checkOutput("mdl_ready", i, {15'h0, ready_w[i]}, {15'h0, e_ready[i]});
      checkOutput("mdl_hit", i, {15'h0, hit_w[i]}, {15'h0, e_hit[i]});
      if (rd_known[i]) checkOutput("mdl_rdata", i, rdata_w[i], e_rdata[i]);
    end
  end

  typedef struct {
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] d;
    logic        we;
    logic        e_ready;
    logic        e_hit;
    logic        chk_rd;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs [$];

  function automatic void vec(input logic r, input logic [15:0] a, input logic [15:0] d,
                              input logic we, input logic er, input logic eh,
                              input logic chk, input logic [15:0] erd);
    vec_t v;
    v.rst_n = r; v.a = a; v.d = d; v.we = we;
    v.e_ready = er; v.e_hit = eh; v.chk_rd = chk; v.e_rdata = erd;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [15:0] ra;
    logic [15:0] rd;

    // Instance A (one wait state): each row is one edge, expectations after it.
    vec(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000);
    vec(1, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0000);
    vec(1, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000);
    vec(1, 16'h0000, 16'h0000, 0, 1, 1, 0, 16'h0000);
    vec(1, 16'h0005, 16'hBEEF, 1, 0, 1, 0, 16'h0000);
    vec(1, 16'h0005, 16'hBEEF, 1, 0, 1, 0, 16'h0000);
    vec(1, 16'h0005, 16'hBEEF, 1, 1, 1, 1, 16'hBEEF);
    vec(1, 16'h0005, 16'hBEEF, 1, 1, 1, 1, 16'hBEEF);
    vec(1, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'hBEEF);
    vec(1, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000);
    vec(1, 16'h0000, 16'h0000, 0, 1, 1, 0, 16'h0000);
    vec(1, 16'h0005, 16'h0000, 0, 0, 1, 0, 16'h0000);
    vec(1, 16'h0005, 16'h0000, 0, 0, 1, 0, 16'h0000);
    vec(1, 16'h0005, 16'h0000, 0, 1, 1, 1, 16'hBEEF);
    for (int k = 0; k < 5; k++)
      vec(1, 16'h0005, 16'h1234, 1, k >= 2, 1, k >= 2, 16'h1234);
    vec(1, 16'h0005, 16'h5678, 1, 0, 1, 1, 16'h1234);
    vec(1, 16'h0005, 16'h5678, 1, 0, 1, 0, 16'h0000);
    vec(1, 16'h0005, 16'h5678, 1, 1, 1, 1, 16'h5678);
    vec(1, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000);
    vec(1, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000);
    vec(1, 16'h0000, 16'h0000, 0, 1, 1, 0, 16'h0000);
    vec(1, 16'h0005, 16'h0000, 0, 0, 1, 0, 16'h0000);
    vec(1, 16'h0005, 16'h0000, 0, 0, 1, 0, 16'h0000);
    vec(1, 16'h0005, 16'h0000, 0, 1, 1, 1, 16'h5678);

    applyStimulus(0, 16'h0000, 16'h0000, 0);
    foreach (vecs[n]) begin
      applyStimulus(vecs[n].rst_n, vecs[n].a, vecs[n].d, vecs[n].we);
      @(posedge clk);
      #1;
      checkOutput("tbl_ready", 0, {15'h0, ready_w[0]}, {15'h0, vecs[n].e_ready});
      checkOutput("tbl_hit", 0, {15'h0, hit_w[0]}, {15'h0, vecs[n].e_hit});
      if (vecs[n].chk_rd) checkOutput("tbl_rdata", 0, rdata_w[0], vecs[n].e_rdata);
    end

    // Instance C: window 0x0100..0x010F, zero wait states.
    applyStimulus(1, 16'h0105, 16'h7777, 1);  holdEdges(6);
    checkOutput("oor_in_ready", 2, {15'h0, ready_w[2]}, 16'h1);
    checkOutput("oor_in_rdata", 2, rdata_w[2], 16'h7777);
    applyStimulus(1, 16'h0200, 16'hAAAA, 1);  holdEdges(6);
    checkOutput("oor_wr_hit", 2, {15'h0, hit_w[2]}, 16'h0);
    checkOutput("oor_wr_rdata", 2, rdata_w[2], 16'h0000);
    applyStimulus(1, 16'h0200, 16'h0000, 0);  holdEdges(6);
    checkOutput("oor_rd_ready", 2, {15'h0, ready_w[2]}, 16'h1);
    checkOutput("oor_rd_rdata", 2, rdata_w[2], 16'h0000);
    applyStimulus(1, 16'h0105, 16'h0000, 0);  holdEdges(1);
    checkOutput("ws0_edge1_ready", 2, {15'h0, ready_w[2]}, 16'h0);
    holdEdges(1);
    checkOutput("ws0_edge2_ready", 2, {15'h0, ready_w[2]}, 16'h1);
    checkOutput("oor_keep_rdata", 2, rdata_w[2], 16'h7777);
    checkOutput("oor_keep_hit", 2, {15'h0, hit_w[2]}, 16'h1);

    // Instance B: a write abandoned by an address switch during WAIT.
    applyStimulus(1, 16'h0003, 16'h0033, 1);  holdEdges(6);
    applyStimulus(1, 16'h0004, 16'h0044, 1);  holdEdges(6);
    applyStimulus(1, 16'h0003, 16'h1111, 1);  holdEdges(1);
    applyStimulus(1, 16'h0004, 16'h1111, 0);
    for (int k = 1; k <= 4; k++) begin
      holdEdges(1);
      checkOutput("restart_wait_ready", 1, {15'h0, ready_w[1]}, 16'h0);
    end
    holdEdges(1);
    checkOutput("restart_ready", 1, {15'h0, ready_w[1]}, 16'h1);
    checkOutput("restart_rdata", 1, rdata_w[1], 16'h0044);
    applyStimulus(1, 16'h0003, 16'h0000, 0);  holdEdges(6);
    checkOutput("dropped_wr_b", 1, rdata_w[1], 16'h0033);
    checkOutput("dropped_wr_a", 0, rdata_w[0], 16'h0033);

    // Reset during a pending write leaves the RAM untouched.
    applyStimulus(1, 16'h0007, 16'h0042, 1);  holdEdges(6);
    applyStimulus(1, 16'h0007, 16'h9999, 1);  holdEdges(1);
    applyStimulus(0, 16'h0007, 16'h9999, 1);  holdEdges(1);
    for (int i = 0; i < N_INST; i++) begin
      checkOutput("rst_ready", i, {15'h0, ready_w[i]}, 16'h0);
      checkOutput("rst_rdata", i, rdata_w[i], 16'h0000);
    end
    applyStimulus(1, 16'h0007, 16'h0000, 0);  holdEdges(6);
    checkOutput("rst_keep_a", 0, rdata_w[0], 16'h0042);
    checkOutput("rst_keep_b", 1, rdata_w[1], 16'h0042);

    // Random traffic, checked every cycle by the reference model.
    for (int s = 0; s < 300; s++) begin
      case ($urandom_range(0, 4))
        0: ra = 16'($urandom_range(0, 7));
        1: ra = 16'h0100 + 16'($urandom_range(0, 17));
        2: ra = 16'hFFF4 + 16'($urandom_range(0, 11));
        3: ra = 16'h0200;
        default: ra = 16'($urandom);
      endcase
      rd = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      applyStimulus($urandom_range(0, 39) != 0, ra, rd, 1'($urandom_range(0, 1)));
      holdEdges($urandom_range(1, 6));
    end

    applyStimulus(1, 16'h0000, 16'h0000, 0);
    holdEdges(8);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
